// File: rtl/aes_enc_round_ctrl_if.sv
// Handshake, key-store and round-datapath bundle for aes_enc_round_ctrl.
// AES_CTRL_STAT_EN adds the block-counter signals blk_cnt / cnt_clr.
interface aes_enc_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   key_mode;
  logic [127:0] din;
  logic [3:0]   key_addr;
  logic [127:0] round_key;
  logic [3:0]   round_times;
  logic [1:0]   round_key_mode;
  logic [127:0] round_din;
  logic [127:0] round_dout;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
  logic         mode_err;
`ifdef AES_CTRL_STAT_EN
  logic [15:0]  blk_cnt;
  logic         cnt_clr;

  modport master (
    output in_valid, key_mode, din, round_key, round_dout, out_ready, cnt_clr,
    input  in_ready, key_addr, round_times, round_key_mode, round_din, out_valid, dout, mode_err, blk_cnt
  );
  modport slave (
    input  in_valid, key_mode, din, round_key, round_dout, out_ready, cnt_clr,
    output in_ready, key_addr, round_times, round_key_mode, round_din, out_valid, dout, mode_err, blk_cnt
  );
`else
  modport master (
    output in_valid, key_mode, din, round_key, round_dout, out_ready,
    input  in_ready, key_addr, round_times, round_key_mode, round_din, out_valid, dout, mode_err
  );
  modport slave (
    input  in_valid, key_mode, din, round_key, round_dout, out_ready,
    output in_ready, key_addr, round_times, round_key_mode, round_din, out_valid, dout, mode_err
  );
`endif
endinterface

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES encryption controller driving an external one-round datapath.
// Define AES_CTRL_STAT_EN to add a saturating output-handshake counter.
module aes_enc_round_ctrl #(
  parameter int KEY_RD_LAT = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_enc_round_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      2'd1:    nr_of = 4'd12;
      2'd2:    nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  state_t       state_r, state_nxt_s;
  logic [127:0] data_r, data_nxt_s;
  logic [3:0]   cnt_r, cnt_nxt_s;
  logic [1:0]   mode_r, mode_nxt_s;
  logic         mode_err_r, mode_err_nxt_s;
  logic         ready_r, ready_nxt_s;
  logic         valid_r, valid_nxt_s;
  logic [3:0]   key_addr_r, key_addr_nxt_s;
  logic [3:0]   nr_s;
  logic         accept_s;
  logic         out_hs_s;

  assign nr_s     = nr_of(mode_r);
  assign accept_s = ready_r && bus.in_valid;
  assign out_hs_s = valid_r && bus.out_ready;

  // FSM transitions plus state-register, round-counter and mode updates
  always_comb begin
    state_nxt_s    = state_r;
    data_nxt_s     = data_r;
    cnt_nxt_s      = cnt_r;
    mode_nxt_s     = mode_r;
    mode_err_nxt_s = mode_err_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = INIT;
          data_nxt_s  = bus.din;
          if (bus.key_mode == 2'd3) begin
            mode_nxt_s     = 2'd0;
            mode_err_nxt_s = 1'b1;
          end else begin
            mode_nxt_s     = bus.key_mode;
            mode_err_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INIT: begin
        data_nxt_s  = data_r ^ bus.round_key;
        cnt_nxt_s   = 4'd1;
        state_nxt_s = ROUND;
      end
      ROUND: begin
        data_nxt_s = bus.round_dout;
        // >= keeps the counter bounded even if mode_r were ever corrupted
        if (cnt_r >= nr_s) begin
          state_nxt_s = DONE;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = ROUND;
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      DONE: begin
        if (out_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // handshake flags and key address, precomputed from the next state
  always_comb begin
    ready_nxt_s    = (state_nxt_s == IDLE);
    valid_nxt_s    = (state_nxt_s == DONE);
    key_addr_nxt_s = 4'd0;
    if (KEY_RD_LAT == 0) begin
      if (state_nxt_s == ROUND) begin
        key_addr_nxt_s = cnt_nxt_s;
      end else begin
        key_addr_nxt_s = 4'd0;
      end
    end else begin
      // one cycle ahead; the final round has no following key to prefetch
      case (state_nxt_s)
        INIT: key_addr_nxt_s = 4'd1;
        ROUND: begin
          if (cnt_nxt_s < nr_s) begin
            key_addr_nxt_s = cnt_nxt_s + 4'd1;
          end else begin
            key_addr_nxt_s = 4'd0;
          end
        end
        default: key_addr_nxt_s = 4'd0;
      endcase
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      data_r     <= 128'd0;
      cnt_r      <= 4'd0;
      mode_r     <= 2'd0;
      mode_err_r <= 1'b0;
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      key_addr_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      data_r     <= data_nxt_s;
      cnt_r      <= cnt_nxt_s;
      mode_r     <= mode_nxt_s;
      mode_err_r <= mode_err_nxt_s;
      ready_r    <= ready_nxt_s;
      valid_r    <= valid_nxt_s;
      key_addr_r <= key_addr_nxt_s;
    end
  end

  assign bus.in_ready       = ready_r;
  assign bus.out_valid      = valid_r;
  assign bus.dout           = data_r;
  assign bus.round_din      = data_r;
  assign bus.round_times    = cnt_r;
  assign bus.round_key_mode = mode_r;
  assign bus.key_addr       = key_addr_r;
  assign bus.mode_err       = mode_err_r;

`ifdef AES_CTRL_STAT_EN
  logic [15:0] blk_cnt_r;

  // output-handshake counter; clear beats increment, increment saturates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt_r <= 16'd0;
    end else if (bus.cnt_clr) begin
      blk_cnt_r <= 16'd0;
    end else if (out_hs_s && (blk_cnt_r != 16'hFFFF)) begin
      blk_cnt_r <= blk_cnt_r + 16'd1;
    end else begin
      blk_cnt_r <= blk_cnt_r;
    end
  end

  assign bus.blk_cnt = blk_cnt_r;
`endif
endmodule
